// File: rtl/ghost_collision_ctrl.sv
// Player/ghost contact detection and the death, respawn and game-over sequencer.
// Runs once per frame on frame_clk; respawn feeds the mover resets, freeze gates movers and renderer.
module ghost_collision_ctrl #(
   parameter int NUM_GHOSTS   = 4,
   parameter int HITBOX       = 12,
   parameter int START_LIVES  = 3,
   parameter int DEATH_FRAMES = 60,
   parameter int GRACE_FRAMES = 90
) (
   input  logic                      frame_clk,
   input  logic                      Reset,
   input  logic [9:0]                pac_x,
   input  logic [9:0]                pac_y,
   input  logic [NUM_GHOSTS*10-1:0]  ghost_x,
   input  logic [NUM_GHOSTS*10-1:0]  ghost_y,
   input  logic                      restart,
   output logic [2:0]                lives,
   output logic                      hit,
   output logic [1:0]                hit_id,
   output logic                      freeze,
   output logic                      respawn,
   output logic                      game_over,
   output logic                      grace
);

   localparam int         GW = $clog2(GRACE_FRAMES + 1);
   localparam int         DW = $clog2(DEATH_FRAMES + 1);
   localparam logic [9:0] HB = 10'(HITBOX);

   typedef enum logic [1:0] {PLAY, DYING, RESPAWN, GAME_OVER} state_t;

   state_t          state_reg, state_next;
   logic [2:0]      lives_reg, lives_next;
   logic            hit_reg, hit_next;
   logic [1:0]      hit_id_reg, hit_id_next;
   logic [GW-1:0]   grace_cnt_reg, grace_cnt_next;
   logic [DW-1:0]   death_cnt_reg, death_cnt_next;

   logic [NUM_GHOSTS-1:0] contact;
   logic [1:0]            first_id;

   // Raw distances; tunnel wrap positions are deliberately not treated specially.
   generate
      for (genvar gi = 0; gi < NUM_GHOSTS; gi++) begin : g_contact
         logic [9:0] gx, gy, dx, dy;
         assign gx = ghost_x[gi*10 +: 10];
         assign gy = ghost_y[gi*10 +: 10];
         assign dx = (pac_x >= gx) ? pac_x - gx : gx - pac_x;
         assign dy = (pac_y >= gy) ? pac_y - gy : gy - pac_y;
         assign contact[gi] = (dx < HB) && (dy < HB);
      end
   endgenerate

   // Lowest-indexed ghost wins when several touch in the same frame.
   always_comb begin
      first_id = '0;
      for (int i = NUM_GHOSTS - 1; i >= 0; i--) begin
         if (contact[i]) first_id = 2'(i);
      end
   end

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state_reg     <= PLAY;
         lives_reg     <= 3'(START_LIVES);
         hit_reg       <= 1'b0;
         hit_id_reg    <= '0;
         grace_cnt_reg <= GW'(GRACE_FRAMES);
         death_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         lives_reg     <= lives_next;
         hit_reg       <= hit_next;
         hit_id_reg    <= hit_id_next;
         grace_cnt_reg <= grace_cnt_next;
         death_cnt_reg <= death_cnt_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      lives_next     = lives_reg;
      hit_next       = 1'b0;
      hit_id_next    = hit_id_reg;
      grace_cnt_next = grace_cnt_reg;
      death_cnt_next = death_cnt_reg;
      case (state_reg)
         PLAY: begin
            if (grace_cnt_reg != '0) begin
               grace_cnt_next = grace_cnt_reg - GW'(1);
            end else if (|contact) begin
               hit_next       = 1'b1;
               hit_id_next    = first_id;
               lives_next     = (lives_reg != 3'd0) ? lives_reg - 3'd1 : 3'd0;
               death_cnt_next = DW'(DEATH_FRAMES - 1);
               state_next     = DYING;
            end
         end
         DYING: begin
            if (death_cnt_reg == '0)
               state_next = (lives_reg == 3'd0) ? GAME_OVER : RESPAWN;
            else
               death_cnt_next = death_cnt_reg - DW'(1);
         end
         RESPAWN: begin
            state_next     = PLAY;
            grace_cnt_next = GW'(GRACE_FRAMES);
         end
         GAME_OVER: begin
            if (restart) begin
               lives_next = 3'(START_LIVES);
               state_next = RESPAWN;
            end
         end
         default: state_next = PLAY;
      endcase
   end

   assign lives     = lives_reg;
   assign hit       = hit_reg;
   assign hit_id    = hit_id_reg;
   assign freeze    = (state_reg != PLAY);
   assign respawn   = (state_reg == RESPAWN);
   assign game_over = (state_reg == GAME_OVER);
   assign grace     = (grace_cnt_reg != '0);

endmodule

// File: tb/tb_ghost_collision_ctrl.sv
// Bench for ghost_collision_ctrl: directed game scenarios followed by random play,
// every frame checked against a frame-level model of the game rules.
module tb_ghost_collision_ctrl;

   logic        frame_clk;
   logic        Reset;
   logic [9:0]  pac_x, pac_y;
   logic [39:0] ghost_x, ghost_y;
   logic        restart;
   logic [2:0]  lives;
   logic        hit;
   logic [1:0]  hit_id;
   logic        freeze, respawn, game_over, grace;

   int n_cmp = 0;
   int n_bad = 0;

   // model of the game: frames left in each phase rather than a state code
   int m_lives, m_grace_left, m_dying_left, m_hit, m_hit_id;
   bit m_respawn_now, m_over;

   ghost_collision_ctrl dut (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .pac_x     (pac_x),
      .pac_y     (pac_y),
      .ghost_x   (ghost_x),
      .ghost_y   (ghost_y),
      .restart   (restart),
      .lives     (lives),
      .hit       (hit),
      .hit_id    (hit_id),
      .freeze    (freeze),
      .respawn   (respawn),
      .game_over (game_over),
      .grace     (grace)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   task automatic chk(input string tag, input logic [9:0] obs, input int exp);
      n_cmp++;
      assert (obs === 10'(exp)) else begin
         n_bad++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   function automatic int first_contact();
      int dx, dy;
      for (int i = 0; i < 4; i++) begin
         dx = int'(pac_x) - int'(ghost_x[i*10 +: 10]);
         dy = int'(pac_y) - int'(ghost_y[i*10 +: 10]);
         if (dx < 0) dx = -dx;
         if (dy < 0) dy = -dy;
         if (dx < 12 && dy < 12) return i;
      end
      return -1;
   endfunction

   task automatic model_step();
      int c;
      c = first_contact();
      if (Reset) begin
         m_lives = 3; m_grace_left = 90; m_dying_left = 0;
         m_respawn_now = 0; m_over = 0; m_hit = 0; m_hit_id = 0;
      end else begin
         m_hit = 0;
         if (m_respawn_now) begin
            m_respawn_now = 0;
            m_grace_left  = 90;
         end else if (m_over) begin
            if (restart) begin
               m_over = 0; m_lives = 3; m_respawn_now = 1;
            end
         end else if (m_dying_left > 0) begin
            m_dying_left--;
            if (m_dying_left == 0) begin
               if (m_lives == 0) m_over = 1;
               else m_respawn_now = 1;
            end
         end else if (m_grace_left > 0) begin
            m_grace_left--;
         end else if (c >= 0) begin
            m_hit = 1; m_hit_id = c;
            m_lives = (m_lives > 0) ? m_lives - 1 : 0;
            m_dying_left = 60;
         end
      end
   endtask

   task automatic tick();
      @(posedge frame_clk);
      model_step();
      #1;
      chk("lives",     10'(lives),     m_lives);
      chk("hit",       10'(hit),       m_hit);
      chk("hit_id",    10'(hit_id),    m_hit_id);
      chk("freeze",    10'(freeze),    int'(m_dying_left > 0 || m_respawn_now || m_over));
      chk("respawn",   10'(respawn),   int'(m_respawn_now));
      chk("game_over", 10'(game_over), int'(m_over));
      chk("grace",     10'(grace),     int'(m_grace_left > 0));
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic place(input int i, input int x, input int y);
      ghost_x[i*10 +: 10] = 10'(x);
      ghost_y[i*10 +: 10] = 10'(y);
   endtask

   task automatic all_far();
      for (int i = 0; i < 4; i++) place(i, 600 + 20 * i, 450);
   endtask

   initial begin
      int px, py, ev;
      Reset = 1'b1; restart = 1'b0;
      pac_x = 10'd200; pac_y = 10'd200;
      all_far();
      place(2, 200, 200);
      ticks(2);
      chk("reset_lives", 10'(lives), 3);
      chk("reset_grace", 10'(grace), 1);
      chk("reset_freeze", 10'(freeze), 0);
      Reset = 1'b0;

      // contact from frame 0 is ignored for the full grace period
      ticks(90);
      chk("grace_last_hit", 10'(hit), 0);
      chk("grace_done", 10'(grace), 0);
      tick();
      chk("first_hit", 10'(hit), 1);
      chk("first_hit_id", 10'(hit_id), 2);
      chk("first_lives", 10'(lives), 2);
      chk("first_freeze", 10'(freeze), 1);

      all_far();
      ticks(59);
      chk("dying_freeze", 10'(freeze), 1);
      chk("dying_no_resp", 10'(respawn), 0);
      tick();
      chk("resp_pulse", 10'(respawn), 1);
      tick();
      chk("resp_end", 10'(respawn), 0);
      chk("play_freeze", 10'(freeze), 0);
      chk("play_grace", 10'(grace), 1);
      chk("play_lives", 10'(lives), 2);

      // dx = 12 is outside the hitbox, dx = 11 inside; lowest index wins
      place(1, 212, 200); place(3, 188, 200);
      ticks(93);
      chk("dx12_nohit", 10'(hit), 0);
      place(1, 189, 200); place(3, 211, 200);
      tick();
      chk("dx11_hit", 10'(hit), 1);
      chk("dx11_id", 10'(hit_id), 1);
      chk("dx11_lives", 10'(lives), 1);

      all_far();
      ticks(61);
      place(0, 200, 200);
      ticks(91);
      chk("third_hit", 10'(hit), 1);
      chk("third_lives", 10'(lives), 0);
      ticks(60);
      chk("over", 10'(game_over), 1);
      chk("over_no_resp", 10'(respawn), 0);
      ticks(5);
      chk("over_hold", 10'(game_over), 1);
      restart = 1'b1;
      tick();
      chk("restart_resp", 10'(respawn), 1);
      chk("restart_lives", 10'(lives), 3);
      restart = 1'b0;
      tick();
      chk("restart_grace", 10'(grace), 1);
      chk("restart_over", 10'(game_over), 0);

      // reset in the middle of DYING with contact still present
      ticks(91);
      chk("mid_hit", 10'(hit), 1);
      ticks(29);
      Reset = 1'b1;
      tick();
      chk("mid_rst_lives", 10'(lives), 3);
      chk("mid_rst_freeze", 10'(freeze), 0);
      chk("mid_rst_resp", 10'(respawn), 0);
      chk("mid_rst_hit", 10'(hit), 0);
      Reset = 1'b0;

      // random play
      for (int t = 0; t < 4000; t++) begin
         px = int'($urandom_range(600, 30));
         py = int'($urandom_range(440, 30));
         pac_x = 10'(px); pac_y = 10'(py);
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(3) == 0)
               place(i, px + int'($urandom_range(30)) - 15, py + int'($urandom_range(30)) - 15);
            else
               place(i, int'($urandom_range(1023)), int'($urandom_range(1023)));
         end
         ev = int'($urandom_range(499));
         Reset   = (ev == 0);
         restart = ($urandom_range(7) == 0);
         tick();
      end
      Reset = 1'b0; restart = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
